// File: rtl/shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_arbiter
// Brief    : Round-robin sharing of one external barrel shifter between two
//            requesters; latches operands, captures result, pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0,
    input  logic [DATA_WIDTH-1:0]  data0,
    input  logic [SHAMT_WIDTH-1:0] amt0,
    input  logic [1:0]             op0,
    input  logic                   req1,
    input  logic [DATA_WIDTH-1:0]  data1,
    input  logic [SHAMT_WIDTH-1:0] amt1,
    input  logic [1:0]             op1,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   done0,
    output logic                   done1,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  shf_data,
    output logic [SHAMT_WIDTH-1:0] shf_amt,
    output logic [1:0]             shf_op,
    input  logic [DATA_WIDTH-1:0]  shf_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_SRA  = 2'b01;
    localparam logic [1:0] c_OP_RSVD = 2'b11;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_grant;
    logic                   r_owner;
    logic                   w_arb_phase;
    logic                   w_grant_valid;
    logic                   w_grant_id;
    logic [DATA_WIDTH-1:0]  w_win_data;
    logic [SHAMT_WIDTH-1:0] w_win_amt;
    logic [1:0]             w_win_op;
    logic [1:0]             w_win_op_mapped;

    // Arbitration is open in IDLE and RESP so back-to-back work skips IDLE.
    always_comb begin
        w_arb_phase   = (r_state == S_IDLE) || (r_state == S_RESP);
        w_grant_valid = w_arb_phase && (req0 || req1);
        if (req0 && req1) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1;
        end
    end

    always_comb begin
        w_win_data      = w_grant_id ? data1 : data0;
        w_win_amt       = w_grant_id ? amt1  : amt0;
        w_win_op        = w_grant_id ? op1   : op0;
        w_win_op_mapped = (w_win_op == c_OP_RSVD) ? c_OP_SRA : w_win_op;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_next_state = w_grant_valid ? S_SHIFT : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pulses default low each cycle; a grant and a capture never coincide
    // because grants happen only outside SHIFT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            result       <= '0;
            shf_data     <= '0;
            shf_amt      <= '0;
            shf_op       <= '0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (w_grant_valid) begin
                shf_data     <= w_win_data;
                shf_amt      <= w_win_amt;
                shf_op       <= w_win_op_mapped;
                r_owner      <= w_grant_id;
                r_last_grant <= w_grant_id;
                ack0         <= ~w_grant_id;
                ack1         <= w_grant_id;
            end
            if (r_state == S_SHIFT) begin
                result <= shf_result;
                done0  <= ~r_owner;
                done1  <= r_owner;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_arbiter
// Brief    : Directed and random checks of shift_unit_arbiter against a
//            transaction-level reference model with an attached shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit_arbiter;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic [SW-1:0] amt0 = '0, amt1 = '0;
    logic [1:0]    op0 = '0, op1 = '0;
    logic          ack0, ack1, done0, done1, busy;
    logic [DW-1:0] result, shf_data, shf_result;
    logic [SW-1:0] shf_amt;
    logic [1:0]    shf_op;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    shift_unit_arbiter #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) u_dut (
        .clock(clock), .reset(reset),
        .req0(req0), .data0(data0), .amt0(amt0), .op0(op0),
        .req1(req1), .data1(data1), .amt1(amt1), .op1(op1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .shf_data(shf_data), .shf_amt(shf_amt), .shf_op(shf_op),
        .shf_result(shf_result)
    );

    // External shared shifter
    assign shf_result = (shf_op == 2'b00) ? (shf_data << shf_amt) :
                        (shf_op == 2'b10) ? (shf_data >> shf_amt) :
                        DW'($signed(shf_data) >>> shf_amt);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: shifts as plain arithmetic on unsigned values
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                              input logic [1:0] op);
        longint unsigned pw = 64'd1 << a;
        longint unsigned dd = {32'd0, d};
        longint unsigned nd = {32'd0, ~d};
        if (op == 2'b00)      return 32'((dd * pw) % 64'h1_0000_0000);
        else if (op == 2'b10) return 32'(dd / pw);
        else if (d[31])       return ~32'(nd / pw);
        else                  return 32'(dd / pw);
    endfunction

    // Transaction-level model: the unit is either free, computing, or delivering
    int            m_phase;
    logic          m_last, m_owner;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_amt;
    logic [1:0]    m_op;
    logic          e_ack0, e_ack1, e_done0, e_done1;
    logic [DW-1:0] e_result;

    task automatic model_reset();
        m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
        m_data = '0; m_amt = '0; m_op = '0;
        e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0; e_result = '0;
    endtask

    task automatic model_edge();
        int  w;
        e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0;
        if (m_phase == 1) begin
            e_result = ref_shift(m_data, m_amt, m_op);
            if (m_owner) e_done1 = 1; else e_done0 = 1;
            m_phase = 2;
        end else begin
            w = -1;
            if (req0 && req1) w = m_last ? 0 : 1;
            else if (req0)    w = 0;
            else if (req1)    w = 1;
            if (w == 0) begin
                m_data = data0; m_amt = amt0; m_op = op0; e_ack0 = 1;
            end else if (w == 1) begin
                m_data = data1; m_amt = amt1; m_op = op1; e_ack1 = 1;
            end
            if (w >= 0) begin
                m_owner = (w == 1); m_last = (w == 1); m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("ack0",     ack0,     e_ack0);
        chk("ack1",     ack1,     e_ack1);
        chk("done0",    done0,    e_done0);
        chk("done1",    done1,    e_done1);
        chk("result",   result,   e_result);
        chk("busy",     busy,     m_phase != 0);
        chk("shf_data", shf_data, m_data);
        chk("shf_amt",  shf_amt,  m_amt);
        chk("shf_op",   shf_op,   (m_op == 2'b11) ? 2'b01 : m_op);
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset(); else model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n_done;
        logic [3:0]    order;
        logic [DW-1:0] snap_data;
        logic [31:0]   b2b_exp [1:3];
        model_reset();

        // Reset state
        step();
        step();
        chk("rst_result", result, 32'h0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // Single request
        req0 = 1; data0 = 32'h0000_00F0; amt0 = 4; op0 = 2'b00;
        step();
        chk("single_ack0", ack0, 1'b1);
        req0 = 0;
        step();
        chk("single_done0", done0, 1'b1);
        chk("single_res", result, 32'h0000_0F00);
        step();

        // Simultaneous requests alternate starting with requester 0
        do_reset();
        req0 = 1; req1 = 1;
        data0 = 32'h8000_0000; amt0 = 31; op0 = 2'b01;
        data1 = 32'h8000_0000; amt1 = 31; op1 = 2'b10;
        n_done = 0; order = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done0) chk("alt_res0", result, 32'hFFFF_FFFF);
            if (done1) chk("alt_res1", result, 32'h0000_0001);
            if (done0 || done1) begin
                if (n_done < 4) order[n_done] = done1;
                n_done++;
            end
        end
        chk("alt_count", n_done, 4);
        chk("alt_order", order, 4'b1010);
        req0 = 0; req1 = 0;
        step(); step();

        // Back-to-back on requester 1
        b2b_exp[1] = 32'hF800_0000; b2b_exp[2] = 32'hFC00_0000; b2b_exp[3] = 32'hFE00_0000;
        req1 = 1; data1 = 32'hF000_0000; op1 = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            amt1 = 5'(i);
            step();
            chk("b2b_ack1", ack1, 1'b1);
            if (i == 3) req1 = 0;
            step();
            chk("b2b_done1", done1, 1'b1);
            chk("b2b_res", result, b2b_exp[i]);
        end
        step();

        // Reset during SHIFT
        req0 = 1; req1 = 1; data0 = 32'h1234_5678; amt0 = 3; op0 = 2'b00;
        step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("midrst_ack0", ack0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("midrst_tie_ack0", ack0, 1'b1);
        req0 = 0; req1 = 0;
        step(); step();

        // Operand changed before grant, op=11 remap, amt=0 passthrough
        req1 = 1; data1 = 32'h0F0F_0000; amt1 = 8; op1 = 2'b10;
        step();
        req1 = 0; req0 = 1; data0 = 32'hAAAA_0001; amt0 = 0; op0 = 2'b11;
        step();
        data0 = 32'h9ABC_DEF0;
        step();
        chk("late_op_data", shf_data, 32'h9ABC_DEF0);
        chk("rsvd_op", shf_op, 2'b01);
        req0 = 0;
        step();
        chk("amt0_res", result, 32'h9ABC_DEF0);
        step();

        // Idle: nothing moves
        snap_data = shf_data;
        for (int i = 0; i < 5; i++) step();
        chk("idle_busy", busy, 1'b0);
        chk("idle_shf", shf_data, snap_data);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            data0 = $urandom(); data1 = $urandom();
            amt0  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom());
            amt1  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom());
            op0   = 2'($urandom()); op1 = 2'($urandom());
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Controls one shared 32-bit combinational shift datapath (SRA / SLL / SRL barrel shifter) and shares it between two requesters, e.g. the ALU issue path and the mult/div unit.
- Arbitrates round-robin, latches the winner's operands, drives the shifter and registers the result.
- Returns the result to the winner with a one-cycle done pulse.
- Sits between the requesters and the shifter instance. The shifter's input and result ports connect externally.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request (level).
- data0  in  DATA_WIDTH  requester 0 operand.
- amt0  in  SHAMT_WIDTH  requester 0 shift amount.
- op0  in  2  requester 0 op: 00 SLL, 01 SRA, 10 SRL, 11 reserved (treated as SRA).
- req1, data1, amt1, op1  in  1/DATA_WIDTH/SHAMT_WIDTH/2  requester 1, same meaning.
- ack0, ack1  out  1  one-cycle pulse: request accepted and operands latched.
- done0, done1  out  1  one-cycle pulse: result valid for that requester.
- result  out  DATA_WIDTH  registered shift result; held until next capture.
- busy  out  1  high in SHIFT and RESP.
- shf_data  out  DATA_WIDTH  operand to shared shifter.
- shf_amt  out  SHAMT_WIDTH  amount to shared shifter.
- shf_op  out  2  op select to shared shifter (11 remapped to 01).
- shf_result  in  DATA_WIDTH  shifter output; combinational from shf_*.

Behaviour:
- Reset values: all outputs 0, state=IDLE, last_grant=1 (req0 wins first tie), owner=0.
- States:
  - IDLE: arbitrate.
  - SHIFT: shifter evaluates latched operands.
  - RESP: result delivered; arbitrate again.
- Arbitration runs in IDLE and RESP, combinational on req0/req1:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - Neither high: IDLE stays IDLE; RESP goes to IDLE.
- On the edge a winner is chosen:
  - latch data/amt/op into shf_data/shf_amt/shf_op;
  - owner and last_grant are set to the winner;
  - ackN is asserted (registered, high for exactly the SHIFT cycle);
  - state goes to SHIFT.
- SHIFT, exactly 1 cycle:
  - shf_* stable from latches.
  - On the exiting edge: result <= shf_result, done[owner] <= 1, state goes to RESP.
- RESP, exactly 1 cycle: done[owner] high; result valid.
- Latency: req sampled at edge E -> ack during E..E+1 -> done and result during E+1..E+2.
- Throughput: one operation per 2 cycles when requests are back-to-back (RESP goes straight to SHIFT).
- Requester rule:
  - Hold req and operands stable until ack is seen.
  - Deassert req at the edge ending the ack cycle, unless issuing a new operation.
  - A req still high in RESP counts as a new request.
- Operand changes while not yet acked are allowed; the values at the grant edge are what get latched.
- ack0/ack1 never high together; done0/done1 never high together; ackN and doneN never high in the same cycle.
- shf_* hold their last latched values in IDLE/RESP (no toggling without a grant).
- amt=0 passes the operand through unchanged; the shifter, not the controller, defines the result.
- Reset asserted mid-operation: immediately clear state, pending done and ack; result goes to 0. No done is issued for the aborted operation.

Test Plan:
- Single request: req0=1, data0=0x0000_00F0, amt0=4, op0=SLL, bench shifter attached -> ack0 one cycle after the sampling edge; done0 one cycle later with result=0x0000_0F00; done1 never asserted.
- Simultaneous requests after reset: req0=req1=1 held continuously, shifts of 0x8000_0000 by 31 (op0 SRA, op1 SRL) -> grants alternate 0,1,0,1. Results alternate 0xFFFF_FFFF (done0) and 0x0000_0001 (done1), one done every 2 cycles.
- Back-to-back same requester: req1 held for 3 ops (amt 1, 2, 3, SRA on 0xF000_0000) -> done1 pulses 2 cycles apart with 0xF800_0000, 0xFC00_0000, 0xFE00_0000; no idle cycle between them.
- Reset mid-op: assert reset during the SHIFT cycle -> ack, done and result immediately 0; state IDLE. After release, req0 again wins the first tie.
- Boundaries: amt=0 -> result equals the operand. op=11 -> shf_op=01. Operand changed before grant -> the grant-edge value is used. No requests -> busy stays 0 and shf_* stay static.
